ex_div_seq: RTL and testbench
=============================

Name: ex_div_seq

Overview:
- Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, sitting beside the EX stage ALU.
- EX presents operands and holds start_i; this block runs a radix-2 restoring division over WIDTH cycles and raises stall_req_o to the pipeline control until the result is ready.
- Handles divide-by-zero and signed overflow as fast paths, and aborts on branch flush.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  division requested by the instruction in EX; held high by EX until ready_o.
- signed_i  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- rem_sel_i  input  1  1 = return remainder, 0 = return quotient.
- dividend_i  input  WIDTH  rs1 value.
- divisor_i  input  WIDTH  rs2 value.
- cancel_i  input  1  flush (taken branch/jump ahead of this instruction); aborts the operation.
- result_o  output  WIDTH  quotient or remainder; valid only while ready_o=1.
- ready_o  output  1  result valid this cycle.
- stall_req_o  output  1  request to freeze the pipeline at EX.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, internal registers=0, result_o=0, ready_o=0, stall_req_o=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - stall_req_o = start_i & ~cancel_i (combinational); ready_o=0.
  - On an edge with start_i=1 and cancel_i=0, latch operands, signed_i and rem_sel_i.
  - Divisor==0: quotient=all ones, remainder=dividend; go to DONE.
  - signed_i=1, dividend=0x8000_0000 and divisor=0xFFFF_FFFF: quotient=0x8000_0000, remainder=0; go to DONE.
  - Otherwise go to CALC with counter=0.
- Operand prep: if signed_i=1, operate on magnitudes.
  - Negate the final quotient when the operand signs differ.
  - Negate the final remainder when the dividend is negative.
- CALC:
  - One restoring step per cycle: shift {rem,quo} left by 1, trial subtract divisor magnitude; if non-negative, keep the difference and set the quotient LSB to 1.
  - Counter increments each cycle; after the step with counter==WIDTH-1, apply sign fixups and go to DONE.
  - stall_req_o=1, ready_o=0.
- DONE:
  - ready_o=1, stall_req_o=0; result_o = remainder if rem_sel_i else quotient.
  - Next edge goes unconditionally to IDLE. The pipeline advances on this cycle, so the start_i seen in the following IDLE belongs to the next instruction.
- Latency:
  - Normal path: start cycle (stall) + WIDTH CALC cycles (stall) + 1 DONE cycle. ready_o is high WIDTH+1 cycles after start_i is first sampled; 33 stall cycles for WIDTH=32.
  - Fast path: 1 stall cycle, then DONE.
- cancel_i:
  - In any state, the next state is IDLE, ready_o=0, and the latched operands are discarded.
  - While cancel_i=1, stall_req_o is 0 combinationally.
  - start_i and cancel_i both high in IDLE: cancel wins and no operation starts.
- Operand changes on dividend_i/divisor_i after the start edge are ignored.
- Back-to-back divisions: DONE -> IDLE -> a new start on the next cycle. This gives one non-stalled IDLE-free gap cycle, with no extra bubble beyond the DONE cycle.
- Reset mid-CALC: immediate return to the reset values; no partial result is ever flagged ready.
- result_o holds the last value outside DONE. Consumers must qualify it with ready_o.

Test Plan:
- DIVU 100/7 (signed_i=0, rem_sel_i=0): stall_req_o high for 33 cycles, then ready_o=1 for 1 cycle, result_o=14. Repeat with rem_sel_i=1: result_o=2.
- DIV -7/2 (0xFFFF_FFF9, 0x2), signed_i=1: quotient 0xFFFF_FFFD (-3). REM gives 0xFFFF_FFFF (-1). 7/-2 gives quotient -3 and remainder 1.
- Divide by zero: DIVU 0x1234/0 gives result_o=0xFFFF_FFFF, and REMU gives 0x1234. ready_o is asserted on the 2nd cycle after start, with exactly 1 stall cycle.
- Signed overflow: DIV 0x8000_0000/0xFFFF_FFFF gives 0x8000_0000; REM gives 0. Both take the fast-path timing.
- cancel_i pulsed during CALC counter=10: state returns to IDLE and stall_req_o drops the cycle cancel_i is high. No ready_o pulse follows; a new DIVU 9/3 then returns 3 with full latency.
- Async reset: assert rst_n=0 mid-CALC between clock edges. All outputs go to 0 immediately; after release with start_i=1, the full 33-cycle operation completes correctly.

Source files
------------

// File: rtl/ex_div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer (radix-2 restoring), stalling EX until done.
// Divide-by-zero and signed overflow finish in one stall cycle; a flush aborts at any point.
module ex_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             rem_sel_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             stall_req_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
    logic             negQuo_q, negQuo_d, negRem_q, negRem_d, remSel_q, remSel_d;

    logic             dvdNeg, dvsNeg;
    logic [WIDTH-1:0] dvdMag, dvsMag, stepRem, stepQuo, fixQuo, fixRem;
    logic [WIDTH:0]   trial;

    always_comb begin
        dvdNeg = signed_i & dividend_i[WIDTH-1];
        dvsNeg = signed_i & divisor_i[WIDTH-1];
        dvdMag = dvdNeg ? -dividend_i : dividend_i;
        dvsMag = dvsNeg ? -divisor_i : divisor_i;
        // The partial remainder stays below the divisor, so one extra bit holds the trial difference.
        trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (trial[WIDTH]) begin
            stepRem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            stepQuo = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            stepRem = trial[WIDTH-1:0];
            stepQuo = {quo_q[WIDTH-2:0], 1'b1};
        end
        fixQuo = negQuo_q ? -stepQuo : stepQuo;
        fixRem = negRem_q ? -stepRem : stepRem;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        result_d    = result_q;
        negQuo_d    = negQuo_q;
        negRem_d    = negRem_q;
        remSel_d    = remSel_q;
        stall_req_o = 1'b0;
        ready_o     = 1'b0;
        case (state_q)
            IDLE: begin
                stall_req_o = start_i;
                if (start_i) begin
                    remSel_d = rem_sel_i;
                    if (divisor_i == '0) begin
                        result_d = rem_sel_i ? dividend_i : '1;
                        state_d  = DONE;
                    end else if (signed_i && dividend_i == MinInt && divisor_i == '1) begin
                        result_d = rem_sel_i ? '0 : MinInt;
                        state_d  = DONE;
                    end else begin
                        rem_d    = '0;
                        quo_d    = dvdMag;
                        dvs_d    = dvsMag;
                        negQuo_d = dvdNeg ^ dvsNeg;
                        negRem_d = dvdNeg;
                        cnt_d    = '0;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                stall_req_o = 1'b1;
                rem_d       = stepRem;
                quo_d       = stepQuo;
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    result_d = remSel_q ? fixRem : fixQuo;
                    state_d  = DONE;
                end
            end
            DONE: begin
                ready_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush overrides everything, and nothing asks for a stall while reset is held.
        if (cancel_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            result_d    = result_q;
            ready_o     = 1'b0;
            stall_req_o = 1'b0;
        end
        if (!rst_n) begin
            stall_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            negQuo_q <= 1'b0;
            negRem_q <= 1'b0;
            remSel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            negQuo_q <= negQuo_d;
            negRem_q <= negRem_d;
            remSel_q <= remSel_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Randomized self-checking bench for ex_div_seq against an arithmetic RV32M division model.
module tb_ex_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        signed_i;
    logic        rem_sel_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int checks = 0;
    int errors = 0;

    ex_div_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .rem_sel_i  (rem_sel_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stall_req_o(stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V division semantics written with wide integer arithmetic.
    function automatic logic [31:0] refModel(input logic sgn, input logic remSel,
                                             input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            q = longint'(32'hFFFF_FFFF);
            r = longint'(a);
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            q = sa / sb;
            r = sa % sb;
        end
        return remSel ? r[31:0] : q[31:0];
    endfunction

    function automatic int refStalls(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    task automatic applyStimulus(input logic sgn, input logic remSel,
                                 input logic [31:0] a, input logic [31:0] b, input string tag);
        int stalls = 0;
        int cycles = 0;
        logic [31:0] expRes;
        int expStalls;
        expRes    = refModel(sgn, remSel, a, b);
        expStalls = refStalls(sgn, a, b);
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = sgn;
        rem_sel_i  = remSel;
        dividend_i = a;
        divisor_i  = b;
        #1;
        checkOutput({tag, " ready low at start"}, 32'(ready_o), 32'd0);
        while (cycles < 100 && !ready_o) begin
            if (stall_req_o) stalls++;
            @(negedge clk);
            #1;
            cycles++;
            dividend_i = $urandom;
            divisor_i  = $urandom;
        end
        start_i = 1'b0;
        checkOutput({tag, " ready reached"}, 32'(ready_o), 32'd1);
        checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(expStalls));
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expStalls));
        checkOutput({tag, " stall low in done"}, 32'(stall_req_o), 32'd0);
        checkOutput({tag, " result"}, result_o, expRes);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn, rs;
        int          noReady;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        rem_sel_i  = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        cancel_i   = 1'b0;
        #12;
        checkOutput("reset result", result_o, 32'd0);
        checkOutput("reset ready", 32'(ready_o), 32'd0);
        checkOutput("reset stall", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, issued back to back.
        applyStimulus(0, 0, 32'd100, 32'd7, "divu 100/7");
        applyStimulus(0, 1, 32'd100, 32'd7, "remu 100/7");
        applyStimulus(1, 0, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        applyStimulus(1, 1, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
        applyStimulus(1, 0, 32'd7, 32'hFFFF_FFFE, "div 7/-2");
        applyStimulus(1, 1, 32'd7, 32'hFFFF_FFFE, "rem 7/-2");
        applyStimulus(0, 0, 32'h1234, 32'd0, "divu by zero");
        applyStimulus(0, 1, 32'h1234, 32'd0, "remu by zero");
        applyStimulus(1, 1, 32'hFFFF_FF00, 32'd0, "rem signed by zero");
        applyStimulus(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        applyStimulus(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, "rem overflow");
        applyStimulus(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, "divu large");
        applyStimulus(0, 0, 32'hFFFF_FFFF, 32'd1, "divu max/1");

        // Randomized mix, biased toward small and boundary operands.
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom);
            rs  = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 9));
                1: b = b >> $urandom_range(0, 31);
                2: a = 32'h8000_0000;
                default: ;
            endcase
            applyStimulus(sgn, rs, a, b, $sformatf("rand%0d", i));
        end

        // Start and flush together in idle: nothing may start.
        @(negedge clk);
        start_i    = 1'b1;
        cancel_i   = 1'b1;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        #1;
        checkOutput("start+cancel stall", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b0;
        #1;
        checkOutput("start+cancel no op stall", 32'(stall_req_o), 32'd0);
        checkOutput("start+cancel no op ready", 32'(ready_o), 32'd0);

        // Flush while the iteration counter reads 10.
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        rem_sel_i  = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        repeat (11) @(negedge clk);
        #1;
        checkOutput("pre-cancel stall", 32'(stall_req_o), 32'd1);
        cancel_i = 1'b1;
        start_i  = 1'b0;
        #1;
        checkOutput("cancel stall drop", 32'(stall_req_o), 32'd0);
        checkOutput("cancel ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        cancel_i = 1'b0;
        noReady  = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (ready_o || stall_req_o) noReady++;
            @(negedge clk);
        end
        checkOutput("no activity after cancel", 32'(noReady), 32'd0);
        applyStimulus(0, 0, 32'd9, 32'd3, "divu 9/3 after cancel");

        // Asynchronous reset between clock edges in the middle of an operation.
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        rem_sel_i  = 1'b0;
        dividend_i = 32'd50000;
        divisor_i  = 32'd7;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset stall", 32'(stall_req_o), 32'd0);
        checkOutput("async reset ready", 32'(ready_o), 32'd0);
        checkOutput("async reset result", result_o, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(0, 0, 32'd50000, 32'd7, "divu after reset");
        applyStimulus(1, 1, 32'hFFFF_D8F1, 32'd13, "rem after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
